controller_sequencer: RTL and testbench
=======================================

// Module: controller_sequencer
// PURPOSE
//  Control unit of the SAP-1 8-bit microprocessor.
//  - 6-state one-hot ring counter (T1..T6) sequences every instruction.
//  - Decodes the 4-bit op_code from the instruction register into the 12-bit control word plus hlt_n.
//  - Drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
// PARAMETERS
//  none (opcode and T-state encodings are fixed constants in the shared package)
// PORTS
//  clk      in   1  system clock (single clock domain)
//  clr_n    in   1  asynchronous active-low reset
//  op_code  in   4  opcode nibble from instruction register (IR[7:4])
//  cp       out  1  PC count enable (active high)
//  ep       out  1  PC output enable onto bus
//  lm_n     out  1  MAR load (active low)
//  ce_n     out  1  RAM output enable (active low)
//  li_n     out  1  IR load (active low)
//  ei_n     out  1  IR operand output enable (active low)
//  la_n     out  1  accumulator load (active low)
//  ea       out  1  accumulator output enable
//  su       out  1  ALU subtract select (1 = A-B, 0 = A+B)
//  eu       out  1  ALU output enable
//  lb_n     out  1  B register load (active low)
//  lo_n     out  1  output register load (active low)
//  hlt_n    out  1  halt (active low)
//  state    out  6  one-hot T-state: bit0 = T1 ... bit5 = T6
// BEHAVIOUR
//  - Reset (clr_n=0, async): state=6'b000001 (T1); halt flag cleared.
//  - Ring counter advances on the FALLING edge of clk, so control is stable at the rising edge seen by datapath registers.
//  - Sequence: T1->T2->T3->T4->T5->T6->T1, rotate-left by 1.
//  - Illegal state (not one-hot) -> next state T1.
//  - Outputs are combinational from state and op_code. Inactive word:
//    cp=0 ep=0 lm_n=1 ce_n=1 li_n=1 ei_n=1 la_n=1 ea=0 su=0 eu=0 lb_n=1 lo_n=1 hlt_n=1.
//  - Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF; all others are NOP.
//  - Fetch cycle (all opcodes):
//    - T1: ep=1, lm_n=0
//    - T2: cp=1
//    - T3: ce_n=0, li_n=0
//  - T4:
//    - LDA/ADD/SUB: ei_n=0, lm_n=0
//    - OUT: ea=1, lo_n=0
//    - HLT: hlt_n=0
//  - T5:
//    - LDA: ce_n=0, la_n=0
//    - ADD/SUB: ce_n=0, lb_n=0
//    - others: inactive
//  - T6:
//    - ADD: eu=1, la_n=0
//    - SUB: su=1, eu=1, la_n=0
//    - others: inactive
//  - Halt:
//    - Falling edge while in T4 with op_code=HLT sets the halt flag.
//    - While the flag is set: state frozen at T4, hlt_n=0, every other output inactive, op_code ignored.
//    - Only clr_n low clears it.
//  - op_code changes mid-instruction take effect combinationally in the current state; no latching.
//  - clr_n asserted mid-instruction: immediate return to T1 and inactive fetch-T1 word (ep=1, lm_n=0).
// STRUCTURE
//  - Shared package sap1_pkg:
//    - opcode localparams OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT
//    - T-state one-hot constants T1..T6
//    - control word bit indices
//  - Sub-module ring_counter: 6-bit one-hot, negedge clk, async clr_n, hold input driven by the halt flag.
//  - Decode logic stays in this module.
// TESTING
//  - Reset: clr_n=0 for 40 ns (10 ns clk) -> state=000001, ep=1, lm_n=0, hlt_n=1; release -> state 000010,000100,...,100000,000001 on successive falling edges.
//  - op_code=0 (LDA): T4 ei_n=0, lm_n=0; T5 ce_n=0, la_n=0; T6 all inactive.
//  - op_code=1 (ADD) / 2 (SUB): T5 ce_n=0, lb_n=0; T6 eu=1, la_n=0; su=1 only for SUB.
//  - op_code=14 (OUT): T4 ea=1, lo_n=0; T5/T6 inactive; op_code=5 -> T4..T6 fully inactive.
//  - op_code=15 (HLT): reaching T4 -> hlt_n=0, state stays 001000 for 10+ clocks; clr_n pulse -> T1, hlt_n=1.
//  - Async reset at T5 between clock edges -> state=000001 immediately, before any clock edge.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, T-state encoding,
// and control word bit positions.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot T-states of the instruction ring counter
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Control word bit positions, MSB first: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n
  localparam int unsigned CW_WIDTH = 12;
  localparam int unsigned CW_CP    = 11;
  localparam int unsigned CW_EP    = 10;
  localparam int unsigned CW_LM_N  = 9;
  localparam int unsigned CW_CE_N  = 8;
  localparam int unsigned CW_LI_N  = 7;
  localparam int unsigned CW_EI_N  = 6;
  localparam int unsigned CW_LA_N  = 5;
  localparam int unsigned CW_EA    = 4;
  localparam int unsigned CW_SU    = 3;
  localparam int unsigned CW_EU    = 2;
  localparam int unsigned CW_LB_N  = 1;
  localparam int unsigned CW_LO_N  = 0;

  // Every active-low strobe high, every active-high strobe low
  localparam logic [CW_WIDTH-1:0] CW_INACTIVE = 12'h3E3;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-state one-hot ring counter stepping on the falling clock edge.
module ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       hold,
  output logic [5:0] state
);

  logic [5:0] state_next;

  // State register: falling-edge step, asynchronous return to T1
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) state <= T1;
    else        state <= state_next;
  end

  // Next state: rotate left, freeze on hold, recover illegal codes to T1
  always_comb begin
    state_next = T1;
    if (hold) begin
      state_next = state;
    end else begin
      case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = T5;
        T5:      state_next = T6;
        T6:      state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring counter plus opcode decode into
// the control word and halt.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] op_code,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic       hlt_n,
  output logic [5:0] state
);

  logic                halted;
  logic                halt_set;
  logic [CW_WIDTH-1:0] cw;

  assign halt_set = (state == T4) && (op_code == OP_HLT);

  // Halt flag: set on the falling edge that sees HLT in T4, cleared only by reset
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n)        halted <= 1'b0;
    else if (halt_set) halted <= 1'b1;
  end

  // Hold also covers the setting edge so the counter never leaves T4
  ring_counter u_ring (
    .clk   (clk),
    .clr_n (clr_n),
    .hold  (halted | halt_set),
    .state (state)
  );

  // Decode: control word from current T-state and opcode
  always_comb begin
    cw    = CW_INACTIVE;
    hlt_n = 1'b1;
    if (halted) begin
      hlt_n = 1'b0;
    end else begin
      case (state)
        T1: begin
          cw[CW_EP]   = 1'b1;
          cw[CW_LM_N] = 1'b0;
        end
        T2: cw[CW_CP] = 1'b1;
        T3: begin
          cw[CW_CE_N] = 1'b0;
          cw[CW_LI_N] = 1'b0;
        end
        T4: begin
          case (op_code)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CW_EI_N] = 1'b0;
              cw[CW_LM_N] = 1'b0;
            end
            OP_OUT: begin
              cw[CW_EA]   = 1'b1;
              cw[CW_LO_N] = 1'b0;
            end
            OP_HLT:  hlt_n = 1'b0;
            default: ;
          endcase
        end
        T5: begin
          case (op_code)
            OP_LDA: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LA_N] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LB_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if (op_code == OP_ADD || op_code == OP_SUB) begin
            cw[CW_EU]   = 1'b1;
            cw[CW_LA_N] = 1'b0;
            cw[CW_SU]   = (op_code == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer against a T-index/halt model.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] op_code;
  logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt_n;
  logic [5:0] state;

  int passes = 0;
  int total  = 0;

  // Reference model: instruction step 1..6 and halt flag
  int t      = 1;
  bit halted = 1'b0;

  controller_sequencer dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .op_code (op_code),
    .cp      (cp),
    .ep      (ep),
    .lm_n    (lm_n),
    .ce_n    (ce_n),
    .li_n    (li_n),
    .ei_n    (ei_n),
    .la_n    (la_n),
    .ea      (ea),
    .su      (su),
    .eu      (eu),
    .lb_n    (lb_n),
    .lo_n    (lo_n),
    .hlt_n   (hlt_n),
    .state   (state)
  );

  always #5 clk = ~clk;

  // Expected {state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt_n}
  function automatic logic [18:0] expected(input int ts, input logic [3:0] op, input bit hl);
    logic [5:0] st;
    bit mem, arith;
    st    = 6'(1 << (ts - 1));
    mem   = (op <= 4'd2);
    arith = (op == 4'd1) || (op == 4'd2);
    if (hl)
      return {st, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    return {st,
            1'(ts == 2),
            1'(ts == 1),
            1'(!(ts == 1 || (ts == 4 && mem))),
            1'(!(ts == 3 || (ts == 5 && mem))),
            1'(!(ts == 3)),
            1'(!(ts == 4 && mem)),
            1'(!((ts == 5 && op == 4'd0) || (ts == 6 && arith))),
            1'(ts == 4 && op == 4'hE),
            1'(ts == 6 && op == 4'd2),
            1'(ts == 6 && arith),
            1'(!(ts == 5 && arith)),
            1'(!(ts == 4 && op == 4'hE)),
            1'(!(ts == 4 && op == 4'hF))};
  endfunction

  task automatic check(input string tag);
    logic [18:0] act, exp;
    act = {state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt_n};
    exp = expected(t, op_code, halted);
    total++;
    assert (act === exp) passes++;
    else $error("FAIL %s t=%0d op=%h observed=%b expected=%b", tag, t, op_code, act, exp);
  endtask

  // One clock: model steps with the DUT on the falling edge, checks after both edges
  task automatic tick(input string tag);
    @(negedge clk);
    if (!clr_n) begin
      t = 1;
      halted = 1'b0;
    end else if (!halted) begin
      if (t == 4 && op_code == 4'hF) halted = 1'b1;
      else t = (t % 6) + 1;
    end
    #1 check({tag, "_neg"});
    @(posedge clk);
    #1 check({tag, "_pos"});
  endtask

  // Asynchronous reset pulse starting between edges; returns after posedge+1
  task automatic pulse_reset(input string tag);
    clr_n = 1'b0;
    #1;
    t = 1;
    halted = 1'b0;
    check({tag, "_async"});
    tick({tag, "_held"});
    clr_n = 1'b1;
    #1 check({tag, "_release"});
  endtask

  task automatic set_op(input logic [3:0] op, input string tag);
    op_code = op;
    #1 check(tag);
  endtask

  initial begin
    logic [3:0] ops [5];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE; ops[4] = 4'h5;

    clr_n   = 1'b0;
    op_code = 4'h0;
    #40 check("reset");
    #2 clr_n = 1'b1;
    #1 check("release");

    // Plain ring rotation under LDA, then each opcode class for a full instruction
    for (int i = 0; i < 6; i++) tick("ring");
    for (int k = 0; k < 5; k++) begin
      set_op(ops[k], "op_change");
      for (int i = 0; i < 6; i++) tick("decode");
    end

    // Halt: freeze at T4 for many clocks, op_code ignored while halted
    set_op(4'hF, "hlt_op");
    for (int i = 0; i < 16; i++) tick("halt");
    for (int i = 0; i < 4; i++) begin
      set_op(4'($urandom_range(0, 15)), "halt_op_ignored");
      tick("halt_ignored");
    end
    pulse_reset("halt_clear");
    set_op(4'h1, "post_halt_op");

    // Asynchronous reset while in T5
    for (int i = 0; i < 12 && t != 5; i++) tick("to_t5");
    check("at_t5");
    pulse_reset("t5_reset");

    // Randomized opcodes with mid-instruction changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) set_op(4'($urandom_range(0, 15)), "rand_op");
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
      tick("rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
